// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo run controller: host register map,
// CTRL/status bit positions and the run FSM state encoding.
package mc_pkg;

    // Host register addresses
    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_KERT   = 4'd1;
    localparam logic [3:0] ADDR_SE05   = 4'd2;
    localparam logic [3:0] ADDR_SIGSQ  = 4'd3;
    localparam logic [3:0] ADDR_RCMP   = 4'd4;
    localparam logic [3:0] ADDR_N      = 4'd5;
    localparam logic [3:0] ADDR_SUM_LO = 4'd6;
    localparam logic [3:0] ADDR_SUM_HI = 4'd7;
    localparam logic [3:0] ADDR_CNT    = 4'd8;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_CLR_DONE = 2;

    // Run controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mc_host_regs.sv
// Host-visible register file for the run controller. Holds the pricing
// constants and sample count, decodes CTRL commands and muxes read data.
// Parameter registers are write-locked while a run is in progress so the
// datapath sees stable constants for the whole run.
module mc_host_regs
    import mc_pkg::*;
#(
    parameter int PARAM_W = 16,
    parameter int SUM_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [3:0]         addr,
    input  logic [PARAM_W-1:0] wdata,
    input  logic               busy,
    input  logic               aborted,
    input  logic               done,
    input  logic [SUM_W-1:0]   sum,
    input  logic [CNT_W-1:0]   count,
    output logic [PARAM_W-1:0] kert,
    output logic [PARAM_W-1:0] se05sigmat,
    output logic [PARAM_W-1:0] sigmasqrtt,
    output logic [PARAM_W-1:0] rand_compare,
    output logic [CNT_W-1:0]   n_samples,
    output logic               start_cmd,
    output logic               abort_cmd,
    output logic               clr_done_cmd,
    output logic [PARAM_W-1:0] rdata
);

    logic ctrl_wr;

    assign ctrl_wr      = wr_en && (addr == ADDR_CTRL);
    assign start_cmd    = ctrl_wr && wdata[CTRL_START];
    assign abort_cmd    = ctrl_wr && wdata[CTRL_ABORT];
    assign clr_done_cmd = ctrl_wr && wdata[CTRL_CLR_DONE];

    // Parameter register writes, ignored while a run is active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kert         <= '0;
            se05sigmat   <= '0;
            sigmasqrtt   <= '0;
            rand_compare <= '0;
            n_samples    <= '0;
        end else if (wr_en && !busy) begin
            case (addr)
                ADDR_KERT:  kert         <= wdata;
                ADDR_SE05:  se05sigmat   <= wdata;
                ADDR_SIGSQ: sigmasqrtt   <= wdata;
                ADDR_RCMP:  rand_compare <= wdata;
                ADDR_N:     n_samples    <= wdata[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = PARAM_W'({busy, aborted, done});
            ADDR_KERT:   rdata = kert;
            ADDR_SE05:   rdata = se05sigmat;
            ADDR_SIGSQ:  rdata = sigmasqrtt;
            ADDR_RCMP:   rdata = rand_compare;
            ADDR_N:      rdata = PARAM_W'(n_samples);
            ADDR_SUM_LO: rdata = sum[PARAM_W-1:0];
            ADDR_SUM_HI: rdata = sum[SUM_W-1:PARAM_W];
            ADDR_CNT:    rdata = PARAM_W'(count);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/mc_run_ctrl.sv
// Run controller for the Monte Carlo present-value datapath. On a start
// command it clears the datapath, streams N random samples into it, waits
// for the pipeline to drain and captures the accumulated sum.
module mc_run_ctrl
    import mc_pkg::*;
#(
    parameter int RAND_W   = 11,
    parameter int PARAM_W  = 16,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [3:0]         addr,
    input  logic [PARAM_W-1:0] wdata,
    output logic [PARAM_W-1:0] rdata,
    input  logic               rnd_valid,
    input  logic [RAND_W-1:0]  rnd_data,
    output logic               rnd_ready,
    output logic               pv_clr,
    output logic               pv_valid,
    output logic [RAND_W-1:0]  pv_rand,
    output logic [PARAM_W-1:0] pv_kert,
    output logic [PARAM_W-1:0] pv_se05sigmat,
    output logic [PARAM_W-1:0] pv_sigmasqrtt,
    output logic [PARAM_W-1:0] pv_rand_compare,
    input  logic [SUM_W-1:0]   pv_sum,
    output logic               busy,
    output logic               done,
    output logic               irq
);

    // DRAIN lasts PIPE_LAT+1 cycles: one for the registered pv_valid plus
    // the datapath latency, so the last sample is in pv_sum before capture.
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   n_samples;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [SUM_W-1:0]   sum_q;
    logic               aborted;
    logic               start_cmd;
    logic               abort_cmd;
    logic               clr_done_cmd;

    mc_host_regs #(
        .PARAM_W (PARAM_W),
        .SUM_W   (SUM_W),
        .CNT_W   (CNT_W)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .aborted      (aborted),
        .done         (done),
        .sum          (sum_q),
        .count        (count),
        .kert         (pv_kert),
        .se05sigmat   (pv_se05sigmat),
        .sigmasqrtt   (pv_sigmasqrtt),
        .rand_compare (pv_rand_compare),
        .n_samples    (n_samples),
        .start_cmd    (start_cmd),
        .abort_cmd    (abort_cmd),
        .clr_done_cmd (clr_done_cmd),
        .rdata        (rdata)
    );

    // Run FSM with registered handshake, datapath control and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            drain_cnt <= '0;
            sum_q     <= '0;
            pv_rand   <= '0;
            pv_valid  <= 1'b0;
            pv_clr    <= 1'b1;
            rnd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            irq       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (clr_done_cmd) begin
                done <= 1'b0;
            end

            if (busy && abort_cmd) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                aborted   <= 1'b1;
                pv_valid  <= 1'b0;
                rnd_ready <= 1'b0;
                pv_clr    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pv_clr    <= 1'b1;
                        pv_valid  <= 1'b0;
                        rnd_ready <= 1'b0;
                        if (start_cmd) begin
                            state   <= ST_CLEAR;
                            busy    <= 1'b1;
                            count   <= '0;
                            done    <= 1'b0;
                            aborted <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        if (n_samples == '0) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state     <= ST_RUN;
                            pv_clr    <= 1'b0;
                            rnd_ready <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (rnd_valid && rnd_ready) begin
                            pv_rand  <= rnd_data;
                            pv_valid <= 1'b1;
                            count    <= count + CNT_W'(1);
                            if (count + CNT_W'(1) == n_samples) begin
                                state     <= ST_DRAIN;
                                drain_cnt <= '0;
                                rnd_ready <= 1'b0;
                            end
                        end else begin
                            pv_valid <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        pv_valid <= 1'b0;
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= ST_DONE;
                            irq   <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                    ST_DONE: begin
                        sum_q  <= pv_sum;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        pv_clr <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
